// File: rtl/ifetcher_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the decoded optype codes and their width, the RV32I opcodes that
// the front end needs, the fetch FSM state encoding and the next-PC
// predictor.
// The load/store optypes LB..SW form one contiguous range, so later stages
// can classify memory operations with a simple range compare.
package ifetcher_pkg;

    localparam int OPTYPE_W = 6;
    typedef logic [OPTYPE_W-1:0] optype_t;

    localparam optype_t OP_NOP   = 6'd0;
    localparam optype_t OP_LUI   = 6'd1;
    localparam optype_t OP_AUIPC = 6'd2;
    localparam optype_t OP_JAL   = 6'd3;
    localparam optype_t OP_JALR  = 6'd4;
    localparam optype_t OP_BEQ   = 6'd5;
    localparam optype_t OP_BNE   = 6'd6;
    localparam optype_t OP_BLT   = 6'd7;
    localparam optype_t OP_BGE   = 6'd8;
    localparam optype_t OP_BLTU  = 6'd9;
    localparam optype_t OP_BGEU  = 6'd10;
    localparam optype_t OP_LB    = 6'd11;
    localparam optype_t OP_LH    = 6'd12;
    localparam optype_t OP_LW    = 6'd13;
    localparam optype_t OP_LBU   = 6'd14;
    localparam optype_t OP_LHU   = 6'd15;
    localparam optype_t OP_SB    = 6'd16;
    localparam optype_t OP_SH    = 6'd17;
    localparam optype_t OP_SW    = 6'd18;
    localparam optype_t OP_ADDI  = 6'd19;
    localparam optype_t OP_SLTI  = 6'd20;
    localparam optype_t OP_SLTIU = 6'd21;
    localparam optype_t OP_XORI  = 6'd22;
    localparam optype_t OP_ORI   = 6'd23;
    localparam optype_t OP_ANDI  = 6'd24;
    localparam optype_t OP_SLLI  = 6'd25;
    localparam optype_t OP_SRLI  = 6'd26;
    localparam optype_t OP_SRAI  = 6'd27;
    localparam optype_t OP_ADD   = 6'd28;
    localparam optype_t OP_SUB   = 6'd29;
    localparam optype_t OP_SLL   = 6'd30;
    localparam optype_t OP_SLT   = 6'd31;
    localparam optype_t OP_SLTU  = 6'd32;
    localparam optype_t OP_XOR   = 6'd33;
    localparam optype_t OP_SRL   = 6'd34;
    localparam optype_t OP_SRA   = 6'd35;
    localparam optype_t OP_OR    = 6'd36;
    localparam optype_t OP_AND   = 6'd37;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // JAL is followed at fetch time; everything else falls through to pc+4.
    function automatic logic [31:0] predict_npc(input logic [31:0] pc,
                                                input logic [31:0] inst);
        logic [31:0] imm;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        if (inst[6:0] == OPC_JAL)
            predict_npc = pc + imm;
        else
            predict_npc = pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetcher_decoder.sv
// Combinational RV32I decoder: instruction word to 6-bit optype.
// Ports:
//   inst    in   32  instruction word
//   optype  out   6  decoded optype (OP_NOP for unrecognised words, incl. 0)
// Only opcode, funct3 and funct7 bit 5 select the operation; register
// fields are ignored.
module ifetcher_decoder
    import ifetcher_pkg::*;
(
    input  logic [31:0] inst,
    output optype_t     optype
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_fields;

    assign opcode        = inst[6:0];
    assign funct3        = inst[14:12];
    assign alt           = inst[30];
    assign unused_fields = ^{inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        optype = OP_NOP;
        case (opcode)
            OPC_LUI:   optype = OP_LUI;
            OPC_AUIPC: optype = OP_AUIPC;
            OPC_JAL:   optype = OP_JAL;
            OPC_JALR:  optype = OP_JALR;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  optype = OP_BEQ;
                    3'b001:  optype = OP_BNE;
                    3'b100:  optype = OP_BLT;
                    3'b101:  optype = OP_BGE;
                    3'b110:  optype = OP_BLTU;
                    3'b111:  optype = OP_BGEU;
                    default: optype = OP_NOP;
                endcase
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000:  optype = OP_LB;
                    3'b001:  optype = OP_LH;
                    3'b010:  optype = OP_LW;
                    3'b100:  optype = OP_LBU;
                    3'b101:  optype = OP_LHU;
                    default: optype = OP_NOP;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000:  optype = OP_SB;
                    3'b001:  optype = OP_SH;
                    3'b010:  optype = OP_SW;
                    default: optype = OP_NOP;
                endcase
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000:  optype = OP_ADDI;
                    3'b010:  optype = OP_SLTI;
                    3'b011:  optype = OP_SLTIU;
                    3'b100:  optype = OP_XORI;
                    3'b110:  optype = OP_ORI;
                    3'b111:  optype = OP_ANDI;
                    3'b001:  optype = OP_SLLI;
                    default: optype = alt ? OP_SRAI : OP_SRLI;
                endcase
            end
            OPC_OP: begin
                case (funct3)
                    3'b000:  optype = alt ? OP_SUB : OP_ADD;
                    3'b001:  optype = OP_SLL;
                    3'b010:  optype = OP_SLT;
                    3'b011:  optype = OP_SLTU;
                    3'b100:  optype = OP_XOR;
                    3'b101:  optype = alt ? OP_SRA : OP_SRL;
                    3'b110:  optype = OP_OR;
                    default: optype = OP_AND;
                endcase
            end
            default: optype = OP_NOP;
        endcase
    end

endmodule

// File: rtl/ifetcher.sv
// Instruction fetch unit: holds the PC, fetches one word at a time from the
// instruction cache, queues {inst, pc, predicted npc} in a small FIFO and
// issues the queue head to the dispatcher unless downstream is full.
// Ports:
//   clk, rst (sync, active-low), rdy (global enable; low freezes everything)
//   icache_req/icache_addr out, icache_valid/icache_inst in
//   rob_clear/rob_newpc in      mispredict flush and restart PC
//   rob_full/rs_full/lsb_full   any high stalls issue
//   ifetch_valid/inst/pc/optype/prednpc out  queue head to dispatcher
module ifetcher
    import ifetcher_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,
    input  logic        rob_clear,
    input  logic [31:0] rob_newpc,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    output logic        ifetch_valid,
    output logic [31:0] ifetch_inst,
    output logic [31:0] ifetch_pc,
    output optype_t     ifetch_optype,
    output logic [31:0] ifetch_prednpc
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    logic [31:0] q_inst [QUEUE_DEPTH];
    logic [31:0] q_pc   [QUEUE_DEPTH];
    logic [31:0] q_pred [QUEUE_DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, count_next;
    logic [31:0]      pc, fetch_pred;
    fetch_state_t     state, state_next;
    logic             nonempty, pop, enq;

    assign nonempty    = (count != '0);
    assign pop         = rst & rdy & ~rob_clear & nonempty & ~(rob_full | rs_full | lsb_full);
    assign enq         = rst & rdy & ~rob_clear & (state == FETCH) & icache_valid;
    assign count_next  = count + CNT_W'(enq) - CNT_W'(pop);
    assign fetch_pred  = predict_npc(pc, icache_inst);

    assign icache_addr    = pc;
    assign ifetch_valid   = pop;
    assign ifetch_inst    = nonempty ? q_inst[head] : 32'h0;
    assign ifetch_pc      = nonempty ? q_pc[head]   : 32'h0;
    assign ifetch_prednpc = nonempty ? q_pred[head] : 32'h0;

    ifetcher_decoder u_decoder (
        .inst   (ifetch_inst),
        .optype (ifetch_optype)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A flush while a request is outstanding must still swallow the orphaned
    // response, hence DROP. In DROP a repeated flush only moves the pc; the
    // orphan still retires the DROP wait when it arrives.
    always_comb begin
        state_next = state;
        icache_req = 1'b0;
        case (state)
            IDLE: begin
                if (count < FULL_CNT)
                    state_next = FETCH;
            end
            FETCH: begin
                icache_req = 1'b1;
                if (icache_valid)
                    state_next = (count_next < FULL_CNT) ? FETCH : IDLE;
            end
            DROP: begin
                if (icache_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rob_clear) begin
            case (state)
                FETCH:   state_next = icache_valid ? IDLE : DROP;
                DROP:    state_next = icache_valid ? IDLE : DROP;
                default: state_next = IDLE;
            endcase
        end
        if (!rdy || !rst) begin
            state_next = state;
            icache_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (rob_clear) begin
                pc    <= rob_newpc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) begin
                    pc   <= fetch_pred;
                    tail <= tail + PTR_W'(1);
                end
                if (pop)
                    head <= head + PTR_W'(1);
                count <= count_next;
            end
        end
    end

    // Queue storage needs no reset: entries are only read while count says
    // they are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_inst[tail] <= icache_inst;
            q_pc[tail]   <= pc;
            q_pred[tail] <= fetch_pred;
        end
    end

endmodule

// File: tb/tb_ifetcher.sv
// Directed self-checking bench for ifetcher: reset, sequential fetch, JAL
// prediction, backpressure, flushes, rdy freeze and mid-run reset.
module tb_ifetcher;
    import ifetcher_pkg::*;

    localparam logic [31:0] ADDI   = 32'h00100093;
    localparam logic [31:0] JAL_P20 = 32'h020000EF;
    localparam logic [31:0] JAL_M8  = 32'hFF9FF06F;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        icache_req, icache_valid;
    logic [31:0] icache_addr, icache_inst;
    logic        rob_clear;
    logic [31:0] rob_newpc;
    logic        rob_full, rs_full, lsb_full;
    logic        ifetch_valid;
    logic [31:0] ifetch_inst, ifetch_pc, ifetch_prednpc;
    optype_t     ifetch_optype;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ifetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_valid   (icache_valid),
        .icache_inst    (icache_inst),
        .rob_clear      (rob_clear),
        .rob_newpc      (rob_newpc),
        .rob_full       (rob_full),
        .rs_full        (rs_full),
        .lsb_full       (lsb_full),
        .ifetch_valid   (ifetch_valid),
        .ifetch_inst    (ifetch_inst),
        .ifetch_pc      (ifetch_pc),
        .ifetch_optype  (ifetch_optype),
        .ifetch_prednpc (ifetch_prednpc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst,
                                 input logic clr, input logic [31:0] npc);
        icache_valid = v;
        icache_inst  = inst;
        rob_clear    = clr;
        rob_newpc    = npc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkFetch(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, ".req"}, 32'(icache_req), 32'(req));
        checkOutput({tag, ".addr"}, icache_addr, addr);
    endtask

    task automatic checkIssue(input string tag, input logic v, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [31:0] pred,
                              input optype_t opt);
        checkOutput({tag, ".valid"}, 32'(ifetch_valid), 32'(v));
        checkOutput({tag, ".inst"}, ifetch_inst, inst);
        checkOutput({tag, ".pc"}, ifetch_pc, pc);
        checkOutput({tag, ".prednpc"}, ifetch_prednpc, pred);
        checkOutput({tag, ".optype"}, 32'(ifetch_optype), 32'(opt));
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick; tick;
        checkFetch("reset", 1'b0, 32'h0);
        checkIssue("reset", 1'b0, 32'h0, 32'h0, 32'h0, OP_NOP);

        rst = 1'b1; #1;
        tick;
        checkFetch("seq_req0", 1'b1, 32'h0);
        checkOutput("seq_idle_valid", 32'(ifetch_valid), 32'd0);

        applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("seq_req4", 1'b1, 32'h4);
        checkIssue("seq_issue0", 1'b1, ADDI, 32'h0, 32'h4, OP_ADDI);
        applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("seq_req8", 1'b1, 32'h8);
        checkIssue("seq_issue4", 1'b1, ADDI, 32'h4, 32'h8, OP_ADDI);
        applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("seq_reqc", 1'b1, 32'hC);
        checkIssue("seq_issue8", 1'b1, ADDI, 32'h8, 32'hC, OP_ADDI);
        applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("seq_req10", 1'b1, 32'h10);
        checkIssue("seq_issuec", 1'b1, ADDI, 32'hC, 32'h10, OP_ADDI);

        applyStimulus(1'b1, JAL_P20, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("jal_fwd_req", 1'b1, 32'h30);
        checkIssue("jal_fwd_issue", 1'b1, JAL_P20, 32'h10, 32'h30, OP_JAL);

        applyStimulus(1'b1, ADDI, 1'b1, 32'h10);
        checkOutput("clr_same_valid", 32'(ifetch_valid), 32'd0);
        tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("clr_same_idle", 1'b0, 32'h10);
        checkIssue("clr_same_empty", 1'b0, 32'h0, 32'h0, 32'h0, OP_NOP);
        tick;
        checkFetch("clr_same_refetch", 1'b1, 32'h10);

        applyStimulus(1'b1, JAL_M8, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("jal_back_req", 1'b1, 32'h8);
        checkIssue("jal_back_issue", 1'b1, JAL_M8, 32'h10, 32'h8, OP_JAL);
        tick;
        checkFetch("jal_back_wait", 1'b1, 32'h8);
        checkIssue("jal_back_empty", 1'b0, 32'h0, 32'h0, 32'h0, OP_NOP);

        applyStimulus(1'b0, 32'h0, 1'b1, 32'h100);
        checkOutput("drop_clr_valid", 32'(ifetch_valid), 32'd0);
        tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("drop_w1", 1'b0, 32'h100);
        tick;
        checkFetch("drop_w2", 1'b0, 32'h100);
        tick;
        checkFetch("drop_w3", 1'b0, 32'h100);
        applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkFetch("drop_orphan", 1'b0, 32'h100);
        checkIssue("drop_discard", 1'b0, 32'h0, 32'h0, 32'h0, OP_NOP);
        tick;
        checkFetch("drop_refetch", 1'b1, 32'h100);
        checkOutput("drop_refetch_valid", 32'(ifetch_valid), 32'd0);

        rs_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
            checkFetch($sformatf("bp_fill%0d", i), (i < 3), 32'h104 + 32'(4 * i));
            checkIssue($sformatf("bp_hold%0d", i), 1'b0, ADDI, 32'h100, 32'h104, OP_ADDI);
        end
        tick;
        checkFetch("bp_full_idle", 1'b0, 32'h110);
        rs_full = 1'b0; #1;
        checkIssue("bp_rel0", 1'b1, ADDI, 32'h100, 32'h104, OP_ADDI);
        tick;
        checkIssue("bp_rel1", 1'b1, ADDI, 32'h104, 32'h108, OP_ADDI);
        checkFetch("bp_rel1_idle", 1'b0, 32'h110);
        tick;
        checkIssue("bp_rel2", 1'b1, ADDI, 32'h108, 32'h10C, OP_ADDI);
        checkFetch("bp_resume", 1'b1, 32'h110);
        tick;
        checkIssue("bp_rel3", 1'b1, ADDI, 32'h10C, 32'h110, OP_ADDI);
        tick;
        checkIssue("bp_drained", 1'b0, 32'h0, 32'h0, 32'h0, OP_NOP);
        checkFetch("bp_drained_req", 1'b1, 32'h110);

        applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkIssue("rdy_pre", 1'b1, ADDI, 32'h110, 32'h114, OP_ADDI);
        rdy = 1'b0;
        applyStimulus(1'b1, ADDI, 1'b0, 32'h0);
        for (int i = 0; i <= 5; i++) begin
            checkFetch($sformatf("rdy_frz%0d", i), 1'b0, 32'h114);
            checkIssue($sformatf("rdy_frz%0d", i), 1'b0, ADDI, 32'h110, 32'h114, OP_ADDI);
            if (i < 5) tick;
        end
        rdy = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkIssue("rdy_resume", 1'b1, ADDI, 32'h110, 32'h114, OP_ADDI);
        checkFetch("rdy_resume", 1'b1, 32'h114);
        tick;
        checkOutput("rdy_popped", 32'(ifetch_valid), 32'd0);
        checkFetch("rdy_after", 1'b1, 32'h114);

        applyStimulus(1'b1, ADDI, 1'b0, 32'h0); tick; applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkIssue("rst_pre", 1'b1, ADDI, 32'h114, 32'h118, OP_ADDI);
        rst = 1'b0; #1;
        checkOutput("rst_low_valid", 32'(ifetch_valid), 32'd0);
        tick;
        checkFetch("rst_mid", 1'b0, 32'h0);
        checkIssue("rst_mid", 1'b0, 32'h0, 32'h0, 32'h0, OP_NOP);
        rst = 1'b1; #1;
        tick;
        checkFetch("rst_restart", 1'b1, 32'h0);
        checkOutput("rst_restart_valid", 32'(ifetch_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ifetcher.md
# ifetcher

Instruction fetch unit. It sits directly upstream of the dispatcher. It holds the program counter and requests 32-bit instructions from the instruction cache one at a time. Fetched instructions go into a small FIFO instruction queue. Each cycle the unit presents the queue head (instruction, PC, decoded optype, predicted next PC) to the dispatcher, unless a downstream structure is full. A ROB redirect flushes the queue and restarts fetch; JAL is followed at fetch time and all other instructions fall through to PC+4.

## Interface
- QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global enable; low freezes all state
- icache_req  out  1  fetch request, held until icache_valid
- icache_addr  out  32  fetch address (current PC)
- icache_valid  in  1  response strobe, exactly one per accepted request
- icache_inst  in  32  instruction word, valid with icache_valid
- rob_clear  in  1  mispredict flush
- rob_newpc  in  32  restart PC, valid with rob_clear
- rob_full, rs_full, lsb_full  in  1 each  downstream full; any high stalls issue
- ifetch_valid  out  1  head issued to dispatcher this cycle
- ifetch_inst  out  32  head instruction
- ifetch_pc  out  32  head PC
- ifetch_optype  out  6  decoded optype of the head
- ifetch_prednpc  out  32  predicted next PC of the head

## Operation
- FSM states:
  - IDLE: no request. Go to FETCH when count < QUEUE_DEPTH.
  - FETCH: icache_req=1, icache_addr=pc. On icache_valid: enqueue {inst, pc, prednpc}, set pc <= prednpc. Stay in FETCH if space remains after this cycle's enqueue and pop, else go to IDLE.
  - DROP: icache_req=0. Wait for the orphaned response; on icache_valid, discard it and go to IDLE.
- Prediction: if inst[6:0]==7'b1101111 (JAL), prednpc = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). Otherwise prednpc = pc+4. Arithmetic is 32-bit modulo.
- Issue:
  - ifetch_valid = rst & rdy & ~rob_clear & (count!=0) & ~(rob_full|rs_full|lsb_full).
  - Pop the head on the same edge that ifetch_valid is high.
  - When the queue is empty, ifetch_inst, ifetch_pc and ifetch_prednpc drive 0, and ifetch_optype drives the decode of 0.
- Queue:
  - head/tail pointers of log2(QUEUE_DEPTH) bits wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.
  - A simultaneous enqueue and pop leaves count unchanged.
  - No enqueue happens when full. This is guaranteed because FETCH is only entered with space available and count cannot rise while a request is outstanding.
- Flush (rob_clear high, takes priority over everything else):
  - Queue is emptied and pc <= rob_newpc.
  - FETCH without icache_valid goes to DROP.
  - FETCH with icache_valid the same cycle discards the response and goes to IDLE.
  - IDLE stays IDLE; DROP stays DROP.
  - A second rob_clear during DROP only updates pc.
- rdy low: no state, pointer or pc change; icache_req=0; ifetch_valid=0; icache_valid is ignored (the memory side is frozen by the same rdy).
- Reset (rst low at the edge): pc=RESET_PC, state IDLE, queue empty, icache_req=0, icache_addr=RESET_PC, ifetch_valid=0, other issue outputs 0/decode of 0. Reset mid-request abandons the response; the cache is reset by the same rst.

## Timing
- Request-to-issue: icache_valid at cycle t → entry visible at cycle t+1 → earliest ifetch_valid at t+1 (one queue stage, no bypass).
- After a response, the next request starts at t+1 (one IDLE/FETCH evaluation). Peak throughput is one instruction per cache response.
- Flush at cycle t: ifetch_valid=0 at t. The new request is asserted at t+1 from IDLE, or after the orphaned response from DROP.
- Stall signals act combinationally in the same cycle; the head is held, not popped.

## Structure
- defines.v holds:
  - the optype codes (including the LB..SW load/store range) and their 6-bit width
  - opcode constants (JAL, etc.)
  - state encodings IDLE/FETCH/DROP
  - `True/`False
- Sub-module: decoder. Combinational inst[31:0] → optype[5:0], instantiated once on the queue head. It is shared with any later stage needing decode.
- Queue storage: a plain register array inside ifetcher; no separate FIFO module.

## Test plan
- Reset then sequential fetch: RESET_PC=0, cache returns ADDI at 0,4,8 with 1-cycle latency → icache_addr 0,4,8; ifetch_pc 0,4,8 on consecutive issue cycles; ifetch_optype = ADDI.
- JAL at PC 0x10 with imm +0x20 → ifetch_prednpc 0x30; next icache_addr 0x30. JAL imm −8 at 0x10 → next addr 0x08.
- Backpressure: hold rs_full high, feed 4 responses → count=4, FSM goes to IDLE, icache_req=0. Release → four issues in order, then fetch resumes.
- Flush with outstanding request: rob_clear, rob_newpc=0x100 while in FETCH; response arrives 3 cycles later → response discarded, queue empty, next icache_addr=0x100, no ifetch_valid until the new instruction returns.
- Simultaneous events: rob_clear in the same cycle as icache_valid → response dropped, FSM goes to IDLE then FETCH 0x100. Enqueue and pop in one cycle at count=1 → count stays 1.
- rdy low for 5 cycles mid-FETCH, and rst low mid-operation → all state frozen, then resumes exactly; reset returns every output to its reset value on the next edge.
